// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one single-cycle combinational ALU among NREQ requesters. A
//   requester is granted (round-robin by default), its operation is captured
//   into the registers that drive the ALU for one EXEC cycle, and the ALU
//   result is registered and returned with the winner's ID on a valid/ready
//   response channel. ALUSel codes above 9 are never issued to the ALU: the
//   ALU sees sel 0 and the response carries rsp_err=1 with zeroed data.
//   At most one operation is in flight; peak throughput is one op per two
//   cycles (accept -> EXEC -> RESP, next accept during the RESP handshake).
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   : fixed priority, lowest index wins,
//                                      no round-robin pointer.
//                          undefined : round-robin starting after the last
//                                      winner (requester 0 first after reset).
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot or 0)
//   req_sel/req_a/req_b      packed per-requester ALUSel and operands
//   alu_sel/alu_a/alu_b      registered operands to the ALU
//   alu_out/alu_azero        combinational ALU result and a_is_zero flag
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_data/rsp_zero/rsp_err  registered response payload
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_sel,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [3:0]            alu_sel,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_out,
  input  logic                  alu_azero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [IDW-1:0]    grant_s;
  logic              grant_vld_s;
  logic              can_take_s;
  logic              accept_s;
  logic [3:0]        sel_in_s;
  logic [WIDTH-1:0]  a_in_s;
  logic [WIDTH-1:0]  b_in_s;
  logic              illegal_s;
  logic [IDW-1:0]    cap_id_r;
  logic              cap_err_r;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Fixed-priority grant: scanning from the top down lets the lowest valid index win.
  always_comb begin
    grant_s     = {IDW{1'b0}};
    grant_vld_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      grant_s     = req_valid[k] ? IDW'(k) : grant_s;
      grant_vld_s = grant_vld_s | req_valid[k];
    end
  end

`else

  logic [IDW-1:0] last_r;

  // (base + off) mod NREQ for off in 1..NREQ, without a divider.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= NREQ) ? (sum - NREQ) : sum;
    return IDW'(sum);
  endfunction

  // Round-robin grant: scan from farthest to nearest after last_r so the
  // nearest valid requester is the final (winning) assignment.
  always_comb begin
    grant_s     = {IDW{1'b0}};
    grant_vld_s = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      grant_s     = req_valid[wrap_idx(last_r, k)] ? wrap_idx(last_r, k) : grant_s;
      grant_vld_s = grant_vld_s | req_valid[wrap_idx(last_r, k)];
    end
  end

  // Round-robin pointer: remembers the last winner; reset makes requester 0 first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= IDW'(NREQ - 1);
    end else if (accept_s) begin
      last_r <= grant_s;
    end
  end

`endif

  // Accept window: IDLE, or RESP while the current response is being taken.
  // rst_n gating keeps req_ready low for the whole reset interval.
  always_comb begin
    can_take_s = 1'b0;
    case (state_r)
      ST_IDLE: can_take_s = 1'b1;
      ST_RESP: can_take_s = rsp_ready;
      ST_EXEC: can_take_s = 1'b0;
      default: can_take_s = 1'b0;
    endcase
    accept_s  = can_take_s && grant_vld_s && rst_n;
    req_ready = accept_s ? (ONE_HOT0 << grant_s) : {NREQ{1'b0}};
  end

  // Winner's operation, sliced out of the packed request buses.
  always_comb begin
    sel_in_s  = req_sel[4*grant_s +: 4];
    a_in_s    = req_a[WIDTH*grant_s +: WIDTH];
    b_in_s    = req_b[WIDTH*grant_s +: WIDTH];
    illegal_s = (sel_in_s > 4'd9);
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = accept_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = accept_s ? ST_EXEC : ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture: updated only on accept so the ALU inputs never toggle otherwise.
  // Illegal codes are replaced by sel 0 so the ALU never sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sel   <= 4'd0;
      alu_a     <= {WIDTH{1'b0}};
      alu_b     <= {WIDTH{1'b0}};
      cap_id_r  <= {IDW{1'b0}};
      cap_err_r <= 1'b0;
    end else if (accept_s) begin
      alu_sel   <= illegal_s ? 4'd0 : sel_in_s;
      alu_a     <= a_in_s;
      alu_b     <= b_in_s;
      cap_id_r  <= grant_s;
      cap_err_r <= illegal_s;
    end
  end

  // Response register: loaded from the ALU in EXEC, held until the handshake in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= {IDW{1'b0}};
      rsp_data  <= {WIDTH{1'b0}};
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cap_id_r;
          rsp_data  <= cap_err_r ? {WIDTH{1'b0}} : alu_out;
          rsp_zero  <= cap_err_r ? 1'b0 : alu_azero;
          rsp_err   <= cap_err_r;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Randomised + directed bench for alu_arbiter with a stand-in ALU. A
//   transaction-level reference model (winner choice from a pointer, a busy
//   flag with cycle stamps) pushes expected responses into a scoreboard queue;
//   an independent monitor pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_sel;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [3:0]            alu_sel;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_out;
  logic                  alu_azero;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_zero;
  logic                  rsp_err;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_azero(alu_azero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Stand-in ALU
  function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (s)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return WIDTH'($signed(a) >>> b[4:0]);
      4'd8: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      4'd9: return (a < b) ? WIDTH'(1) : WIDTH'(0);
      default: return '0;
    endcase
  endfunction

  assign alu_out   = alu_f(alu_sel, alu_a, alu_b);
  assign alu_azero = (alu_a == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
    int               due;
  } rsp_t;

  rsp_t             sbq[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc = 0;
  int               last_g;
  bit               outstanding;
  int               acc_cyc;
  int               acc_id;
  bit               keep_valid = 1'b0;
  bit               fresh = 1'b1;
  logic [3:0]       m_sel;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  int               grants[$];
  int               gcyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    last_g      = NREQ - 1;
    outstanding = 1'b0;
    acc_cyc     = 0;
    acc_id      = -1;
    m_sel       = '0;
    m_a         = '0;
    m_b         = '0;
    sbq.delete();
  endtask

  function automatic int pick();
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (req_valid[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last_g + k) % NREQ;
      if (req_valid[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [3:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[i]           = 1'b1;
    req_sel[4*i +: 4]      = s;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  // One clock cycle: check and advance the model at the falling edge, then
  // return 1 time unit after the next rising edge.
  task automatic tick();
    int               g;
    bit               can_acc;
    logic [NREQ-1:0]  exp_rdy;
    logic [3:0]       s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    rsp_t             e;
    @(negedge clk);
    chk("alu_sel", alu_sel, m_sel);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    g       = pick();
    can_acc = !outstanding || ((cyc >= acc_cyc + 2) && rsp_ready);
    exp_rdy = '0;
    if (g >= 0 && can_acc) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (outstanding && (cyc >= acc_cyc + 2) && rsp_ready) outstanding = 1'b0;
    acc_id = -1;
    if (g >= 0 && can_acc) begin
      s      = req_sel[4*g +: 4];
      a      = req_a[WIDTH*g +: WIDTH];
      b      = req_b[WIDTH*g +: WIDTH];
      e.id   = g;
      e.err  = (s > 4'd9);
      e.data = e.err ? '0 : alu_f(s, a, b);
      e.zero = e.err ? 1'b0 : (a == '0);
      e.due  = cyc + 2;
      sbq.push_back(e);
      m_sel       = e.err ? 4'd0 : s;
      m_a         = a;
      m_b         = b;
      outstanding = 1'b1;
      acc_cyc     = cyc;
      last_g      = g;
      acc_id      = g;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (!keep_valid && acc_id >= 0) req_valid[acc_id] = 1'b0;
  endtask

  // Response monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fresh = 1'b1;
      end else if (rsp_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_rsp: got rsp_valid=1 id=%0d, expected no response (cycle %0d)", rsp_id, cyc);
        end else begin
          if (fresh) chk("rsp_latency", cyc, sbq[0].due);
          fresh = 1'b0;
          chk("rsp_id", rsp_id, sbq[0].id);
          chk("rsp_data", rsp_data, sbq[0].data);
          chk("rsp_zero", rsp_zero, sbq[0].zero);
          chk("rsp_err", rsp_err, sbq[0].err);
          if (rsp_ready) begin
            void'(sbq.pop_front());
            fresh = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_sel   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_alu_sel", alu_sel, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();

    // Single op from requester 1
    rsp_ready = 1'b1;
    set_req(1, 4'd0, 32'd5, 32'd7);
    tick();
    chk("t2_exec_no_rsp", rsp_valid, 1'b0);
    tick();
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_id", rsp_id, 2'd1);
    chk("t2_rsp_data", rsp_data, 32'd12);
    chk("t2_rsp_err", rsp_err, 1'b0);
    chk("t2_rsp_zero", rsp_zero, 1'b0);

    // Illegal code, then a legal op back-to-back
    set_req(0, 4'd12, 32'd3, 32'd4);
    tick();
    chk("t3_alu_sel_forced", alu_sel, 4'd0);
    chk("t3_alu_a", alu_a, 32'd3);
    tick();
    chk("t3_rsp_err", rsp_err, 1'b1);
    chk("t3_rsp_data", rsp_data, 32'd0);
    set_req(0, 4'd1, 32'd0, 32'd1);
    tick();
    tick();
    chk("t3b_rsp_data", rsp_data, 32'hFFFF_FFFF);
    chk("t3b_rsp_zero", rsp_zero, 1'b1);
    chk("t3b_rsp_err", rsp_err, 1'b0);

    // Backpressure with requester 2 pending
    rsp_ready = 1'b0;
    set_req(2, 4'd2, 32'h0000_FF00, 32'h0000_0FF0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_req_ready", req_ready, '0);
      chk("t5_hold_data", rsp_data, 32'hFFFF_FFFF);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_ready_on_release", req_ready, 4'b0100);
    tick();
    tick();
    chk("t5_rsp_id", rsp_id, 2'd2);
    chk("t5_rsp_data", rsp_data, 32'h0000_0F00);

    // Operands changing while unaccepted: accept-cycle values win
    rsp_ready = 1'b0;
    set_req(3, 4'd7, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      set_req(3, 4'd7, $urandom, $urandom);
    end
    set_req(3, 4'd7, 32'h8000_0000, 32'd4);
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("t6_rsp_id", rsp_id, 2'd3);
    chk("t6_rsp_data", rsp_data, 32'hF800_0000);

    // Reset in the middle of RESP
    rsp_ready = 1'b0;
    tick();
    set_req(1, 4'd0, 32'd1, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rsp_valid", rsp_valid, 1'b0);
    chk("t1_rsp_data", rsp_data, 32'd0);
    chk("t1_rsp_id", rsp_id, 2'd0);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_alu_a", alu_a, 32'd0);
    chk("t1_alu_sel", alu_sel, 4'd0);
    chk("t1_req_ready", req_ready, '0);
    model_reset();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk("t1_no_stale", rsp_valid, 1'b0);

    // All requesters valid continuously
    keep_valid = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom_range(0, 9)), $urandom, $urandom);
    for (int i = 0; i < 30 && grants.size() < 8; i++) begin
      tick();
      if (acc_id >= 0) begin
        grants.push_back(acc_id);
        gcyc.push_back(acc_cyc);
      end
    end
    chk("t4_grant_count", grants.size(), 8);
    for (int k = 0; k < grants.size(); k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("t4_grant_order", grants[k], 0);
`else
      chk("t4_grant_order", grants[k], k % NREQ);
`endif
      if (k > 0) chk("t4_grant_spacing", gcyc[k] - gcyc[k-1], 2);
    end
    keep_valid = 1'b0;
    req_valid  = '0;
    repeat (3) tick();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0) ? '0 : $urandom, $urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          set_req(i, req_sel[4*i +: 4], $urandom, $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    // Drain
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && (sbq.size() != 0 || outstanding); i++) tick();
    chk("drain_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
